// File: rtl/pwm_audio_pkg.sv
// Shared defaults and sizing helpers for the PWM audio output path.
package pwm_audio_pkg;

  localparam int DEFAULT_SAMPLE_WIDTH = 9;
  localparam int DEFAULT_FIFO_DEPTH   = 4;
  localparam int DEFAULT_CLK_DIV      = 1;

  // The occupancy count must represent the full value DEPTH, not just DEPTH-1.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Sample FIFO feeding the PWM duty register; full/empty decided from current level only.
module sample_fifo
  import pwm_audio_pkg::*;
#(
  parameter int WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_push,
  input  logic [WIDTH-1:0]              i_data,
  input  logic                          i_pop,
  output logic [WIDTH-1:0]              o_head,
  output logic [level_width(DEPTH)-1:0] o_level,
  output logic                          o_full,
  output logic                          o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LW    = level_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_en;
  logic             pop_en;

  always_comb begin
    o_full   = (level_q == LW'(DEPTH));
    o_empty  = (level_q == '0);
    push_en  = i_push && !o_full;
    pop_en   = i_pop && !o_empty;
    // Pointers wrap naturally because DEPTH is a power of two.
    wr_ptr_d = wr_ptr_q + PTR_W'(push_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_en);
    level_d  = level_q;
    case ({push_en, pop_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (push_en) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_level = level_q;

endmodule

// File: rtl/pwm_audio_output.sv
// PWM audio output: prescaled period counter, per-period duty reload from a sample FIFO.
module pwm_audio_output
  import pwm_audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  parameter int CLK_DIV      = DEFAULT_CLK_DIV
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [SAMPLE_WIDTH-1:0]            i_sample,
  input  logic                               i_sample_valid,
  output logic                               o_sample_ready,
  output logic                               o_pwm,
  output logic                               o_period_start,
  output logic                               o_underrun,
  input  logic                               i_clear_underrun,
  output logic [level_width(FIFO_DEPTH)-1:0] o_level
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [SAMPLE_WIDTH-1:0] CNT_MAX  = '1;

  logic [DIV_W-1:0]        div_q, div_d;
  logic [SAMPLE_WIDTH-1:0] cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] duty_q, duty_d;
  logic                    pwm_q, pwm_d;
  logic                    period_start_q, period_start_d;
  logic                    underrun_q, underrun_d;
  logic                    tick;
  logic                    wrap;
  logic                    fifo_pop;
  logic [SAMPLE_WIDTH-1:0] fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;

  // Handshake: a sample transfers on a rising edge where i_sample_valid and
  // o_sample_ready are both high; ready depends only on current occupancy.
  sample_fifo #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_sample_valid),
    .i_data  (i_sample),
    .i_pop   (fifo_pop),
    .o_head  (fifo_head),
    .o_level (o_level),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    tick           = (div_q == DIV_LAST);
    wrap           = tick && (cnt_q == CNT_MAX);
    div_d          = tick ? '0 : div_q + DIV_W'(1);
    cnt_d          = tick ? cnt_q + SAMPLE_WIDTH'(1) : cnt_q;
    fifo_pop       = wrap && !fifo_empty;
    duty_d         = fifo_pop ? fifo_head : duty_q;
    period_start_d = wrap;
    pwm_d          = (cnt_q < duty_q);
    // A new underrun takes priority over a coincident clear.
    if (wrap && fifo_empty)    underrun_d = 1'b1;
    else if (i_clear_underrun) underrun_d = 1'b0;
    else                       underrun_d = underrun_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q          <= '0;
      cnt_q          <= '0;
      duty_q         <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      div_q          <= div_d;
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      underrun_q     <= underrun_d;
    end
  end

  // Ready is forced low while in reset even though the empty FIFO could accept.
  assign o_sample_ready = i_rst_n && !fifo_full;
  assign o_pwm          = pwm_q;
  assign o_period_start = period_start_q;
  assign o_underrun     = underrun_q;

endmodule

// File: tb/tb_pwm_audio_output.sv
// Directed bench for pwm_audio_output: default instance plus a CLK_DIV=3 instance.
module tb_pwm_audio_output;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] sample = '0;
  logic       valid = 1'b0;
  logic       clear = 1'b0;
  logic       ready, pwm, ps, underrun;
  logic [2:0] level;

  logic       rst3_n = 1'b0;
  logic [8:0] sample3 = '0;
  logic       valid3 = 1'b0;
  logic       clear3 = 1'b0;
  logic       ready3, pwm3, ps3, underrun3;
  logic [2:0] level3;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  pwm_audio_output u_dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_sample         (sample),
    .i_sample_valid   (valid),
    .o_sample_ready   (ready),
    .o_pwm            (pwm),
    .o_period_start   (ps),
    .o_underrun       (underrun),
    .i_clear_underrun (clear),
    .o_level          (level)
  );

  pwm_audio_output #(.CLK_DIV(3)) u_div3 (
    .i_clk            (clk),
    .i_rst_n          (rst3_n),
    .i_sample         (sample3),
    .i_sample_valid   (valid3),
    .o_sample_ready   (ready3),
    .o_pwm            (pwm3),
    .o_period_start   (ps3),
    .o_underrun       (underrun3),
    .i_clear_underrun (clear3),
    .o_level          (level3)
  );

  // ---------------- clock / reset / driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) step();
  endtask

  task automatic reset_main();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    valid = 1'b0;
    clear = 1'b0;
    sample = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    edge_n = 0;
  endtask

  task automatic reset_div3();
    @(posedge clk);
    #1;
    rst3_n = 1'b0;
    valid3 = 1'b0;
    clear3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst3_n = 1'b1;
    edge_n = 0;
  endtask

  task automatic measure(input int n, output int highs, output int starts, output int first);
    highs = 0; starts = 0; first = -1;
    for (int i = 0; i < n; i++) begin
      step();
      if (pwm === 1'b1) highs++;
      if (ps === 1'b1) begin
        starts++;
        if (first < 0) first = edge_n;
      end
    end
  endtask

  task automatic measure3(input int n, output int highs, output int starts, output int first);
    highs = 0; starts = 0; first = -1;
    for (int i = 0; i < n; i++) begin
      step();
      if (pwm3 === 1'b1) highs++;
      if (ps3 === 1'b1) begin
        starts++;
        if (first < 0) first = edge_n;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #3;
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b expected 0", pwm); end
    checks++; if (ps !== 1'b0) begin errors++; $display("FAIL reset_period_start: got %b expected 0", ps); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    reset_main();
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", ready); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL release_level: got %0d expected 0", level); end
  endtask

  task automatic test_fifty_pct();
    int h, s, f;
    reset_main();
    sample = 9'd256; valid = 1'b1;
    step();
    valid = 1'b0;
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL half_level_push: got %0d expected 1", level); end
    measure(511, h, s, f);
    checks++; if (f !== 512) begin errors++; $display("FAIL half_first_start: got %0d expected 512", f); end
    checks++; if (s !== 1) begin errors++; $display("FAIL half_starts_p0: got %0d expected 1", s); end
    checks++; if (h !== 0) begin errors++; $display("FAIL half_highs_p0: got %0d expected 0", h); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL half_level_pop: got %0d expected 0", level); end
    measure(512, h, s, f);
    checks++; if (h !== 256) begin errors++; $display("FAIL half_highs_p1: got %0d expected 256", h); end
    checks++; if (f !== 1024) begin errors++; $display("FAIL half_second_start: got %0d expected 1024", f); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL half_underrun: got %b expected 1", underrun); end
    step();
    checks++; if (ps !== 1'b0) begin errors++; $display("FAIL half_start_width: got %b expected 0", ps); end
  endtask

  task automatic test_duty_extremes();
    int h, s, f;
    reset_main();
    valid = 1'b1;
    sample = 9'd0;   step();
    sample = 9'd511; step();
    valid = 1'b0;
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL ext_level: got %0d expected 2", level); end
    run_to(512);
    measure(512, h, s, f);
    checks++; if (h !== 0) begin errors++; $display("FAIL ext_duty0_highs: got %0d expected 0", h); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ext_underrun: got %b expected 0", underrun); end
    measure(512, h, s, f);
    checks++; if (h !== 511) begin errors++; $display("FAIL ext_duty511_highs: got %0d expected 511", h); end
  endtask

  task automatic test_back_to_back();
    int h, s, f, h0;
    reset_main();
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample = 9'(11 + i);
      step();
    end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL b2b_level_full: got %0d expected 4", level); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b expected 0", ready); end
    sample = 9'd15;
    run_to(511);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL b2b_level_held: got %0d expected 4", level); end
    step();
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL b2b_level_pop: got %0d expected 3", level); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_pop: got %b expected 1", ready); end
    step();
    valid = 1'b0;
    h0 = (pwm === 1'b1) ? 1 : 0;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL b2b_level_fifth: got %0d expected 4", level); end
    measure(511, h, s, f);
    checks++; if (h + h0 !== 11) begin errors++; $display("FAIL b2b_duty_0: got %0d expected 11", h + h0); end
    for (int p = 1; p < 5; p++) begin
      measure(512, h, s, f);
      checks++; if (h !== 11 + p) begin errors++; $display("FAIL b2b_duty_%0d: got %0d expected %0d", p, h, 11 + p); end
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL b2b_level_end: got %0d expected 0", level); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL b2b_underrun_end: got %b expected 1", underrun); end
  endtask

  task automatic test_underrun();
    int h, s, f;
    reset_main();
    sample = 9'd100; valid = 1'b1;
    step();
    valid = 1'b0;
    run_to(512);
    measure(511, h, s, f);
    checks++; if (h !== 100) begin errors++; $display("FAIL ur_highs_p1: got %0d expected 100", h); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_before: got %b expected 0", underrun); end
    step();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_set: got %b expected 1", underrun); end
    checks++; if (ps !== 1'b1) begin errors++; $display("FAIL ur_period_start: got %b expected 1", ps); end
    measure(512, h, s, f);
    checks++; if (h !== 100) begin errors++; $display("FAIL ur_highs_kept: got %0d expected 100", h); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b expected 1", underrun); end
    clear = 1'b1; step(); clear = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear: got %b expected 0", underrun); end
    run_to(2047);
    clear = 1'b1; step(); clear = 1'b0;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_set_wins: got %b expected 1", underrun); end
    step();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_after_race: got %b expected 1", underrun); end
    clear = 1'b1; step(); clear = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear2: got %b expected 0", underrun); end
  endtask

  task automatic test_reset_mid();
    int h, s, f;
    reset_main();
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample = 9'(200 + i);
      step();
    end
    valid = 1'b0;
    run_to(550);
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_level_pre: got %0d expected 3", level); end
    checks++; if (pwm !== 1'b1) begin errors++; $display("FAIL mid_pwm_pre: got %b expected 1", pwm); end
    rst_n = 1'b0;
    #1;
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL mid_pwm_async: got %b expected 0", pwm); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_level_async: got %0d expected 0", level); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_ready_async: got %b expected 0", ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    edge_n = 0;
    measure(512, h, s, f);
    checks++; if (f !== 512) begin errors++; $display("FAIL mid_first_wrap: got %0d expected 512", f); end
    checks++; if (h !== 0) begin errors++; $display("FAIL mid_highs: got %0d expected 0", h); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL mid_underrun: got %b expected 1", underrun); end
  endtask

  task automatic test_clk_div3();
    int h, s, f;
    reset_div3();
    sample3 = 9'd10; valid3 = 1'b1;
    step();
    valid3 = 1'b0;
    checks++; if (level3 !== 3'd1) begin errors++; $display("FAIL div3_level: got %0d expected 1", level3); end
    measure3(1535, h, s, f);
    checks++; if (f !== 1536) begin errors++; $display("FAIL div3_first_start: got %0d expected 1536", f); end
    checks++; if (s !== 1) begin errors++; $display("FAIL div3_starts_p0: got %0d expected 1", s); end
    measure3(1536, h, s, f);
    checks++; if (h !== 30) begin errors++; $display("FAIL div3_highs: got %0d expected 30", h); end
    checks++; if (f !== 3072) begin errors++; $display("FAIL div3_second_start: got %0d expected 3072", f); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fifty_pct();
    test_duty_extremes();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    test_clk_div3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_audio_output.md
PWM_AUDIO_OUTPUT -- requirements
Module: pwm_audio_output

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 9, sample and PWM-counter width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, sample FIFO entries; power of two, 2 or more.
REQ-003 SHALL have parameter CLK_DIV, default 1, i_clk cycles per PWM counter tick; 1 or more.
REQ-004 SHALL have port i_clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port i_sample, input, SAMPLE_WIDTH bits: unsigned duty value from a channel generator.
REQ-007 SHALL have port i_sample_valid, input, 1 bit: i_sample is valid this cycle.
REQ-008 SHALL have port o_sample_ready, output, 1 bit: the FIFO can accept a sample this cycle.
REQ-009 SHALL have port o_pwm, output, 1 bit: registered PWM output.
REQ-010 SHALL have port o_period_start, output, 1 bit: one-cycle pulse when a new duty value is loaded.
REQ-011 SHALL have port o_underrun, output, 1 bit: sticky flag set when a period starts with the FIFO empty.
REQ-012 SHALL have port i_clear_underrun, input, 1 bit: clears o_underrun.
REQ-013 SHALL have port o_level, output, clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-014 A sample SHALL be accepted iff i_sample_valid and o_sample_ready are both high on a clock edge; the accepted sample is written to the FIFO tail.
REQ-015 o_sample_ready SHALL equal (o_level != FIFO_DEPTH), based on the current occupancy only: no push when full, even if a pop occurs in the same cycle.
REQ-016 A prescaler SHALL assert a tick once every CLK_DIV i_clk cycles; with CLK_DIV=1, every cycle is a tick.
REQ-017 A period counter of SAMPLE_WIDTH bits SHALL increment on each tick and wrap from 2^SAMPLE_WIDTH-1 to 0.
REQ-018 On the tick where the counter wraps, the duty register SHALL load the FIFO head and pop it if the FIFO is non-empty; otherwise it SHALL keep its old value and set o_underrun.
REQ-019 o_period_start SHALL be high for exactly the one i_clk cycle after the wrap tick, whether or not an underrun occurred.
REQ-020 o_pwm SHALL be registered as (counter < duty), one i_clk cycle of latency: duty 0 gives constant low; duty 2^W-1 gives low for one tick per period.
REQ-021 With a simultaneous push and pop, o_level SHALL stay unchanged and FIFO order SHALL be preserved.
REQ-022 When an underrun set and i_clear_underrun occur in the same cycle, the set SHALL win.
REQ-023 o_level SHALL never exceed FIFO_DEPTH and SHALL never underflow below 0.

Reset
REQ-024 While i_rst_n is low, the following SHALL be held at 0: counter, prescaler, duty, FIFO pointers, o_level, o_pwm, o_period_start, o_underrun and o_sample_ready.
REQ-025 In the first cycle after reset release, o_sample_ready SHALL be 1; the first duty load occurs at the first counter wrap.
REQ-026 Reset asserted mid-period SHALL discard all FIFO contents and force o_pwm low immediately, without waiting for a clock edge.

Structure
REQ-027 Package pwm_audio_pkg SHALL hold the default SAMPLE_WIDTH, FIFO_DEPTH and CLK_DIV constants and a level-width function.
REQ-028 The FIFO SHALL be a sub-module named sample_fifo (push/pop/level, asynchronous active-low reset); the prescaler, counter, duty register and flags stay in pwm_audio_output.

Verification
REQ-029 CLK_DIV=1, push 256 after reset -> o_period_start pulses at cycle 512 and every 512 cycles after; o_pwm high 256 cycles and low 256 cycles per period.
REQ-030 Duty 0 then 511 -> o_pwm never high in the first period; exactly 1 low cycle per period in the second.
REQ-031 Push 5 samples back-to-back with no wrap -> o_sample_ready low after the 4th accept, o_level=4, the 5th held; after the wrap pop, ready is high and the 5th is accepted.
REQ-032 Empty FIFO at a wrap with previous duty 100 -> o_pwm keeps 100-cycle highs, o_underrun=1 until i_clear_underrun; clear coinciding with a new underrun leaves the flag 1.
REQ-033 Reset pulsed mid-period with o_level=3 -> o_pwm=0 and o_level=0 immediately; the counter restarts and the first wrap occurs 512 cycles after release.
REQ-034 CLK_DIV=3, duty 10 -> period 1536 i_clk cycles; o_pwm high for 30 cycles per period.
